uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_send` transmitter between `NUM_REQ` byte-stream requesters. It accepts one byte at a time over a valid/ready handshake and drives `uart_en`/`uart_din` with a held enable pulse. It then tracks `uart_tx_busy` through its full rise/fall cycle before granting again. It sits directly in front of `uart_send` at the system clock.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `EN_HOLD`, 4: cycles `uart_en` is held high per byte (≥2).
- `BUSY_TIMEOUT`, 16: max cycles to wait for `uart_tx_busy` to rise after the enable pulse.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte available.
- `req_data` in 8*NUM_REQ: requester i's byte on bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is last of packet (used only with lock feature).
- `req_ready` out NUM_REQ: one-hot; byte i accepted on a clock edge where `req_valid[i] && req_ready[i]`.
- `uart_en` out 1: to `uart_send.uart_en`.
- `uart_din` out 8: to `uart_send.uart_din`, registered.
- `uart_tx_busy` in 1: from `uart_send.uart_tx_busy`.
- `grant_id` out clog2(NUM_REQ): index of the last granted requester.
- `tmo` out 1: one-cycle pulse when busy failed to rise.

## Operation
- FSM states: IDLE, EN, WAIT_HI, WAIT_LO.
- IDLE:
  - `sel` = first i with `req_valid[i]`, searching from `(grant_id+1) mod NUM_REQ` upward with wrap.
  - `req_ready` = onehot(`sel`) when any valid, combinational; otherwise 0.
  - On transfer: `uart_din`<=`req_data[sel]`, `grant_id`<=`sel`, go to EN.
- EN: `uart_en`=1 with `uart_din` stable. A counter runs 0..EN_HOLD-1. Leave for WAIT_HI with `uart_en`<=0 after EN_HOLD cycles.
- WAIT_HI:
  - If `uart_tx_busy`=1, go to WAIT_LO.
  - Otherwise increment the timeout counter. On reaching BUSY_TIMEOUT, pulse `tmo` and go to IDLE. The byte is dropped, not retried.
- WAIT_LO: when `uart_tx_busy`=0, go to IDLE.
- Busy already high in EN: the pulse is still completed, and WAIT_HI exits on its first cycle.
- `req_ready` is 0 in every state except IDLE. `uart_din` holds its value until the next transfer.
- Only one byte is in flight at a time. No internal buffering beyond `uart_din`.

## Timing
- Reset values: `uart_en`=0, `uart_din`=8'h00, `req_ready`=0, `grant_id`=NUM_REQ-1 (so requester 0 has first priority), `tmo`=0, FSM in IDLE.
- Reset mid-byte: all outputs return to reset values immediately (async). Any lock is released.
- Latency: a transfer edge in IDLE makes `uart_en` high in the next cycle, for exactly EN_HOLD cycles.
- Re-grant: the earliest next `req_ready` is the cycle after `uart_tx_busy` is sampled low in WAIT_LO.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- A requester dropping `req_valid` while in IDLE before a transfer is legal. `sel` re-evaluates every cycle.

## Configuration
- `UART_ARB_PKT_LOCK_EN` defined:
  - After a transfer from requester g with `req_last[g]`=0, the arbiter is locked to g.
  - While locked, IDLE considers only `req_valid[g]`; other requesters wait.
  - The lock is released by a transfer with `req_last[g]`=1, by a `tmo`, or by reset.
- Not defined: `req_last` is ignored and every byte is re-arbitrated round-robin.

## Test plan
Bench uses `uart_send` with CLK_FREQ=16, UART_BPS=1.
- Single requester: req 0 sends "Hello World!\n" (13 bytes) back-to-back -> `uart_txd` decodes 48 65 6c 6c 6f 20 57 6f 72 6c 64 21 0a in order. Each `uart_en` pulse is 4 cycles wide, and no pulse occurs while busy=1.
- Contention: reqs 0..3 always valid with data 8'hA0+i -> byte sequence A0 A1 A2 A3 A0…; `grant_id` cycles 0..3.
- Sparse: only reqs 1 and 3 valid -> grants alternate 1,3,1,3; `req_ready` never asserts for 0 or 2.
- Timeout: tie busy low -> `tmo` pulses once, 4+16 cycles after the `uart_en` rise; FSM back in IDLE; next requester granted.
- Reset: assert rst_n low during WAIT_LO -> `uart_en`=0, `req_ready`=0, `grant_id`=3 at once. After release, req 0 is granted first.
- Lock (macro on): req 0 sends 3 bytes with last on byte 3 while req 1 is valid -> output is 0,0,0 then 1. With the macro off, output is 0,1,0,1….

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
//
// Round-robin arbiter that shares one uart_send transmitter between NUM_REQ
// byte-stream requesters. One byte is taken over a valid/ready handshake. It
// is presented on uart_din with uart_en held high for EN_HOLD cycles. The
// arbiter then follows uart_tx_busy through its rise and fall before it
// grants again. If busy never rises within BUSY_TIMEOUT cycles, the byte is
// dropped and tmo pulses.
//
// Optional feature: define UART_ARB_PKT_LOCK_EN to keep the grant on one
// requester until it transfers a byte with req_last set. A timeout or a reset
// also releases the lock. When the macro is undefined, req_last is ignored.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_valid      per-requester byte available
//   req_data       requester i byte on [8i+7:8i]
//   req_last       last byte of a packet (lock feature only)
//   req_ready      one-hot accept, asserted only while idle
//   uart_en        enable pulse to uart_send (registered)
//   uart_din       byte to uart_send (registered, held until next transfer)
//   uart_tx_busy   busy flag from uart_send
//   grant_id       index of the last granted requester
//   tmo            one-cycle pulse when busy failed to rise
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | arbitrate; accept one byte from the selected requester
// S_EN      | hold uart_en high for EN_HOLD cycles
// S_WAIT_HI | wait for uart_tx_busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_LO | wait for uart_tx_busy to fall before granting again
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int EN_HOLD      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       uart_en,
    output logic [7:0]                 uart_din,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       tmo
);

    localparam int GW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (EN_HOLD > BUSY_TIMEOUT) ? EN_HOLD : BUSY_TIMEOUT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EN      = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            uart_en_q, uart_en_d;
    logic [7:0]      uart_din_q, uart_din_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            tmo_q, tmo_d;

    logic [GW-1:0]   sel;
    logic [GW-1:0]   idx;
    logic            sel_ok;
    logic [7:0]      sel_data;
    logic            lock_active;

`ifdef UART_ARB_PKT_LOCK_EN
    logic            lock_q, lock_d;
    logic            sel_last;
    assign lock_active = lock_q;
`else
    logic            unused_req_last;
    assign lock_active     = 1'b0;
    assign unused_req_last = ^req_last;
`endif

    // Rotating-priority search starting at grant_id+1. The loop runs from the
    // farthest offset down to the nearest, so the nearest valid requester
    // overwrites any farther one and no "found" flag is needed.
    always_comb begin
        sel    = grant_id_q;
        sel_ok = 1'b0;
        idx    = '0;
        if (lock_active) begin
            sel_ok = req_valid[grant_id_q];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                idx = GW'((int'(grant_id_q) + k) % NUM_REQ);
                if (req_valid[idx]) begin
                    sel    = idx;
                    sel_ok = 1'b1;
                end
            end
        end

        sel_data = '0;
`ifdef UART_ARB_PKT_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_data = req_data[8*i +: 8];
`ifdef UART_ARB_PKT_LOCK_EN
                sel_last = req_last[i];
`endif
            end
        end
    end

    // Gating with rst_n keeps ready low while reset is held, even though the
    // FSM is already in IDLE.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == S_IDLE && sel_ok) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        uart_en_d  = uart_en_q;
        uart_din_d = uart_din_q;
        grant_id_d = grant_id_q;
        tmo_d      = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_ok) begin
                    uart_din_d = sel_data;
                    grant_id_d = sel;
                    uart_en_d  = 1'b1;
                    cnt_d      = CW'(EN_HOLD - 1);
                    state_d    = S_EN;
`ifdef UART_ARB_PKT_LOCK_EN
                    lock_d     = !sel_last;
`endif
                end
            end
            S_EN: begin
                // Busy may already be high here. The pulse still runs its
                // full length, and WAIT_HI then exits on its first cycle.
                if (cnt_q == '0) begin
                    uart_en_d = 1'b0;
                    cnt_d     = CW'(BUSY_TIMEOUT - 1);
                    state_d   = S_WAIT_HI;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!uart_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            uart_en_q  <= 1'b0;
            uart_din_q <= 8'h00;
            grant_id_q <= GW'(NUM_REQ - 1);
            tmo_q      <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            uart_en_q  <= uart_en_d;
            uart_din_q <= uart_din_d;
            grant_id_q <= grant_id_d;
            tmo_q      <= tmo_d;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign uart_en  = uart_en_q;
    assign uart_din = uart_din_q;
    assign grant_id = grant_id_q;
    assign tmo      = tmo_q;

endmodule
